// File: rtl/mdu_defs.sv
// Shared definitions for the iterative multiply/divide unit:
// operation codes, FSM state encoding and the default datapath width.
package mdu_defs;

    localparam int MDU_WIDTH = 32;

    typedef enum logic [2:0] {
        MDU_MULT  = 3'd0,
        MDU_MULTU = 3'd1,
        MDU_DIV   = 3'd2,
        MDU_DIVU  = 3'd3,
        MDU_MTHI  = 3'd4,
        MDU_MTLO  = 3'd5
    } mdu_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIN  = 2'd2
    } mdu_state_e;

endpackage

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath: either a shift-add multiply step
// (LSB first) or a restoring-divide step (MSB first) on a 2*WIDTH accumulator.
module mdu_step import mdu_defs::*; #(
    parameter int WIDTH = MDU_WIDTH
) (
    input  logic [2*WIDTH-1:0] i_acc,
    input  logic [WIDTH-1:0]   i_opnd,
    input  logic               i_div,
    output logic [2*WIDTH-1:0] o_acc
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_part;
    logic [WIDTH:0] w_diff;

    // Multiply: upper half accumulates the multiplicand, lower half holds
    // the remaining multiplier bits; the whole thing shifts right each step.
    assign w_sum = {1'b0, i_acc[2*WIDTH-1:WIDTH]}
                 + (i_acc[0] ? {1'b0, i_opnd} : {(WIDTH+1){1'b0}});

    // Divide: upper half is the partial remainder, lower half shifts the
    // dividend out and the quotient bits in.
    assign w_part = i_acc[2*WIDTH-1:WIDTH-1];
    assign w_diff = w_part - {1'b0, i_opnd};

    always_comb begin
        o_acc = {w_sum, i_acc[WIDTH-1:1]};
        if (i_div) begin
            if (w_diff[WIDTH])
                o_acc = {w_part[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b0};
            else
                o_acc = {w_diff[WIDTH-1:0], i_acc[WIDTH-2:0], 1'b1};
        end
    end

endmodule

// File: rtl/mdu_iter.sv
// Iterative MIPS multiply/divide unit owning HI/LO. MULT/MULTU/DIV/DIVU take
// WIDTH iterations; MTHI/MTLO complete in a single cycle.
module mdu_iter import mdu_defs::*; #(
    parameter int               WIDTH   = MDU_WIDTH,
    parameter logic [WIDTH-1:0] DIV0_LO = {WIDTH{1'b1}}
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_src_a,
    input  logic [WIDTH-1:0] i_src_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_hi,
    output logic [WIDTH-1:0] o_lo
);

    localparam int CW = $clog2(WIDTH);

    mdu_state_e         r_state;
    logic [CW-1:0]      r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_opnd;
    logic               r_div;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    mdu_op_e            w_op;
    logic               w_signed;
    logic               w_a_neg;
    logic               w_b_neg;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [2*WIDTH-1:0] w_acc_nxt;
    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo;
    logic [WIDTH-1:0]   w_rem;
    logic [WIDTH-1:0]   w_res_hi;
    logic [WIDTH-1:0]   w_res_lo;

    assign w_op     = mdu_op_e'(i_op);
    assign w_signed = (w_op == MDU_MULT) || (w_op == MDU_DIV);
    assign w_a_neg  = w_signed && i_src_a[WIDTH-1];
    assign w_b_neg  = w_signed && i_src_b[WIDTH-1];
    assign w_abs_a  = w_a_neg ? -i_src_a : i_src_a;
    assign w_abs_b  = w_b_neg ? -i_src_b : i_src_b;

    mdu_step #(.WIDTH(WIDTH)) u_step (
        .i_acc  (r_acc),
        .i_opnd (r_opnd),
        .i_div  (r_div),
        .o_acc  (w_acc_nxt)
    );

    // Sign correction is applied to the output of the final iteration so the
    // result lands in HI/LO on the same edge as the last step.
    assign w_prod = r_neg_q ? -w_acc_nxt : w_acc_nxt;
    assign w_quo  = w_acc_nxt[WIDTH-1:0];
    assign w_rem  = w_acc_nxt[2*WIDTH-1:WIDTH];

    always_comb begin
        w_res_hi = w_prod[2*WIDTH-1:WIDTH];
        w_res_lo = w_prod[WIDTH-1:0];
        if (r_div) begin
            w_res_hi = r_neg_r ? -w_rem : w_rem;
            w_res_lo = r_div0 ? DIV0_LO : (r_neg_q ? -w_quo : w_quo);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_opnd  <= '0;
            r_div   <= 1'b0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_FIN: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    if (i_start) begin
                        case (w_op)
                            MDU_MULT, MDU_MULTU: begin
                                r_acc   <= {{WIDTH{1'b0}}, w_abs_b};
                                r_opnd  <= w_abs_a;
                                r_div   <= 1'b0;
                                r_neg_q <= w_a_neg ^ w_b_neg;
                                r_neg_r <= 1'b0;
                                r_div0  <= 1'b0;
                                r_cnt   <= '0;
                                r_state <= ST_RUN;
                                r_busy  <= 1'b1;
                            end
                            MDU_DIV, MDU_DIVU: begin
                                r_acc   <= {{WIDTH{1'b0}}, w_abs_a};
                                r_opnd  <= w_abs_b;
                                r_div   <= 1'b1;
                                r_neg_q <= w_a_neg ^ w_b_neg;
                                r_neg_r <= w_a_neg;
                                r_div0  <= (i_src_b == '0);
                                r_cnt   <= '0;
                                r_state <= ST_RUN;
                                r_busy  <= 1'b1;
                            end
                            MDU_MTHI: r_hi <= i_src_a;
                            MDU_MTLO: r_lo <= i_src_a;
                            default: ;
                        endcase
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH-1)) begin
                        r_hi    <= w_res_hi;
                        r_lo    <= w_res_lo;
                        r_state <= ST_FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_hi   = r_hi;
    assign o_lo   = r_lo;

endmodule

// File: tb/tb_mdu_iter.sv
// Directed self-checking bench for mdu_iter: vector table plus hand-written
// sequences for busy-ignore, MTHI/MTLO, mid-run reset and back-to-back ops.
module tb_mdu_iter;
    import mdu_defs::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    mdu_iter dut (
        .i_clk   (clk),
        .i_reset (reset),
        .i_start (start),
        .i_op    (op),
        .i_src_a (src_a),
        .i_src_b (src_b),
        .o_busy  (busy),
        .o_done  (done),
        .o_hi    (hi),
        .o_lo    (lo)
    );

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive a request for one cycle; returns at the falling edge after acceptance.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(negedge clk);
        start = 1'b0; src_a = $urandom; src_b = $urandom;
    endtask

    // Counts busy samples until done is seen, bounded.
    task automatic wait_done(output int bcnt, output bit ok);
        bcnt = 0;
        ok   = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (busy) bcnt++;
            @(negedge clk);
        end
    endtask

    initial begin
        int  bcnt;
        bit  ok;
        bit  saw;
        int  t1;
        int  t2;

        vecs[0] = '{"multu_max", MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1] = '{"mult_neg",  MDU_MULT,  32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1};
        vecs[2] = '{"div_neg",   MDU_DIV,   32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[3] = '{"divu_zero", MDU_DIVU,  32'd7,        32'd0,        32'h00000007, 32'hFFFFFFFF};
        vecs[4] = '{"div_ovf",   MDU_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[5] = '{"divu_100_3",MDU_DIVU,  32'd100,      32'd3,        32'd1,        32'd33};
        vecs[6] = '{"mult_m1m1", MDU_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1};
        vecs[7] = '{"mult_min2", MDU_MULT,  32'h80000000, 32'd2,        32'hFFFFFFFF, 32'd0};

        reset = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0;
        repeat (3) @(negedge clk);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        reset = 1'b0;

        for (int i = 0; i < 8; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_done(bcnt, ok);
            chk({vecs[i].name, "_done"}, ok, 1);
            chk({vecs[i].name, "_busycnt"}, bcnt, 32);
            chk({vecs[i].name, "_hi"}, hi, vecs[i].hi);
            chk({vecs[i].name, "_lo"}, lo, vecs[i].lo);
            @(negedge clk);
            chk({vecs[i].name, "_done_1cyc"}, done, 0);
        end

        // MTHI during busy is dropped; MTHI while idle lands next cycle.
        issue(MDU_MULTU, 32'd6, 32'd7);
        repeat (3) @(negedge clk);
        start = 1'b1; op = MDU_MTHI; src_a = 32'h1234;
        @(negedge clk);
        start = 1'b0;
        wait_done(bcnt, ok);
        chk("busy_ign_done", ok, 1);
        chk("busy_ign_hi", hi, 0);
        chk("busy_ign_lo", lo, 42);
        @(negedge clk);
        issue(MDU_MTHI, 32'h1234, 32'd0);
        chk("mthi_hi", hi, 32'h1234);
        chk("mthi_lo", lo, 42);
        chk("mthi_done", done, 0);
        chk("mthi_busy", busy, 0);

        // Reserved op code has no effect.
        issue(3'd6, 32'hDEAD, 32'hBEEF);
        chk("rsvd_busy", busy, 0);
        chk("rsvd_hi", hi, 32'h1234);
        chk("rsvd_lo", lo, 42);

        // Reset in the middle of a divide discards everything.
        issue(MDU_MTHI, 32'h11, 32'd0);
        issue(MDU_MTLO, 32'h22, 32'd0);
        chk("pre_hi", hi, 32'h11);
        chk("pre_lo", lo, 32'h22);
        issue(MDU_DIVU, 32'd100, 32'd3);
        repeat (9) @(negedge clk);
        chk("midrun_busy", busy, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_hi", hi, 0);
        chk("abort_lo", lo, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        saw = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done) saw = 1'b1;
            @(negedge clk);
        end
        chk("abort_no_done", saw, 0);

        // Back-to-back: second request presented during the FIN cycle.
        issue(MDU_MULTU, 32'd2, 32'd3);
        wait_done(bcnt, ok);
        chk("b2b_done1", ok, 1);
        t1 = cyc;
        chk("b2b_lo1", lo, 6);
        start = 1'b1; op = MDU_MULTU; src_a = 32'd4; src_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_busy2", busy, 1);
        wait_done(bcnt, ok);
        chk("b2b_done2", ok, 1);
        t2 = cyc;
        chk("b2b_spacing", t2 - t1, 33);
        chk("b2b_lo2", lo, 20);
        chk("b2b_hi2", hi, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Iterative multiply/divide unit beside the ALU in the MIPS datapath.
- Consumes the register file read ports (rs and rt data) and owns the architectural HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU in 32 iterations, and MTHI/MTLO in a single cycle.
- Exports busy so the controller can stall PC update. Exports hi/lo for the MFHI/MFLO write-back select.

Parameters:
- WIDTH, 32, operand and HI/LO width. Iteration count equals WIDTH.
- DIV0_LO, 32'hFFFFFFFF, value written to LO on divide-by-zero.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only when busy=0.
- op  input  3  operation code; encodings are in the package.
- src_a  input  WIDTH  rs data (multiplicand, dividend, or MTHI/MTLO data).
- src_b  input  WIDTH  rt data (multiplier or divisor).
- busy  output  1  iterative operation in progress.
- done  output  1  one-cycle pulse when the HI/LO result is written.
- hi  output  WIDTH  architectural HI.
- lo  output  WIDTH  architectural LO.

Behaviour:
- Reset (synchronous, active-high): hi=0, lo=0, busy=0, done=0, state=IDLE, counter=0. Applies mid-operation: the operation is aborted and no partial result reaches hi/lo.
- States:
  - IDLE: busy=0.
  - RUN: busy=1.
  - FIN: busy=0, done=1, lasts one cycle, then returns to IDLE or accepts a new start.
- Acceptance: at edge E0 with start=1, busy=0 and op in {MULT, MULTU, DIV, DIVU}:
  - latch operands in absolute-value form (signed ops) or raw form (unsigned ops);
  - latch the result-sign flags;
  - counter=0, state=RUN.
- RUN: one iteration per edge, E1..E32.
  - Multiply: shift-add into a 2*WIDTH accumulator, one multiplier bit per cycle, LSB first.
  - Divide: restoring division, one quotient bit per cycle, MSB first.
  - At E32, hi/lo are written with the sign-corrected result and state becomes FIN. done=1 during the cycle after E32.
  - busy is high from after E0 until E32: exactly 32 cycles.
- Results:
  - MULT/MULTU: {hi,lo} = 64-bit product. Signed product negated when the operand signs differ.
  - DIV/DIVU: lo = quotient, hi = remainder.
  - Signed quotient is negated when the operand signs differ. Signed remainder takes the sign of the dividend.
  - 0x80000000 / -1 (signed) gives lo=0x80000000, hi=0 with no exception.
  - Divide by zero gives lo=DIV0_LO and hi=src_a as latched at E0. It still takes 32 cycles.
- MTHI/MTLO: when start=1 and busy=0, hi (or lo) = src_a at that edge. No busy, no done. The other register is unchanged.
- start while busy=1: ignored, no queueing, operands not re-latched. The controller must stall.
- start in FIN: accepted normally. Back-to-back operations are allowed.
- Reserved op codes (6, 7) with start: no effect.
- hi/lo hold their previous values throughout RUN. They change only at E32, on MTHI/MTLO, or on reset.
- Operand inputs may change after E0 without affecting the result.

Decomposition:
- Shared package (mdu_defs):
  - op encodings: MDU_MULT=0, MDU_MULTU=1, MDU_DIV=2, MDU_DIVU=3, MDU_MTHI=4, MDU_MTLO=5;
  - state encodings IDLE/RUN/FIN;
  - the WIDTH default.
- Top-level mdu_iter: FSM, counter, operand/sign capture, sign correction, HI/LO registers.
- One natural sub-module, mdu_step: combinational single-iteration datapath. It takes the accumulator, operand and mode and returns the next accumulator, covering both the shift-add step and the restore-subtract step.

Test Plan:
- MULTU src_a=0xFFFFFFFF, src_b=0xFFFFFFFF -> busy high 32 cycles; done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- MULT src_a=-3 (0xFFFFFFFD), src_b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1. Repeat with DIV src_a=-7, src_b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU src_a=7, src_b=0 -> lo=0xFFFFFFFF, hi=0x00000007 after 32 cycles. Then DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- MULTU 6*7 accepted. During busy, start with MTHI src_a=0x1234 -> ignored. Final hi=0, lo=42. Then MTHI 0x1234 while idle -> hi=0x1234 next cycle, lo stays 42, done stays 0.
- Preload hi=0x11, lo=0x22 via MTHI/MTLO. Start DIVU 100/3, assert reset at cycle 10 of RUN -> next cycle hi=0, lo=0, busy=0, done never pulses.
- Back-to-back: issue MULTU 2*3 with start held at the FIN cycle for MULTU 4*5 -> done pulses twice, 33 cycles apart. Final lo=20, hi=0.
